regfile_32x64: RTL and testbench
================================

// Module: regfile_32x64
// PURPOSE
//   Architectural register file feeding the decode-stage read-port mux trees.
//   Holds 32 registers of DATA_W bits, with one write port driven by write-back and two read ports.
//   Each read port selects one register bit-sliced through mux32_1 instances (one per bit).
//   X31 is hardwired to zero.
//   Write-to-read bypass gives same-cycle forwarding, so decode sees the value write-back is committing.
// PARAMETERS
//   DATA_W    64   register width in bits
//   ZERO_REG  31   index of the hardwired-zero register
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset (0 = in reset)
//   wr_en      in   1       write-back commit strobe
//   wr_addr    in   5       destination register index
//   wr_data    in   DATA_W  write-back value
//   rd_addr_a  in   5       read port A index (Rn)
//   rd_addr_b  in   5       read port B index (Rm/Rd)
//   rd_data_a  out  DATA_W  read port A value
//   rd_data_b  out  DATA_W  read port B value
// BEHAVIOUR
//   Reset
//   - reset=0 asynchronously clears all 32 registers to 0.
//   - While reset=0, rd_data_a and rd_data_b are 0 and the bypass is disabled.
//   - A write presented while reset=0 is discarded.
//   - Deassertion takes effect at the next rising clk edge; no write occurs on the deasserting edge if wr_en=0.
//   Write
//   - On a rising clk edge with reset=1, wr_en=1 and wr_addr!=ZERO_REG, reg[wr_addr] <= wr_data.
//   - A write to ZERO_REG is dropped; its storage stays 0.
//   - wr_en=0 leaves every register unchanged.
//   Read
//   - Combinational, zero-cycle latency.
//   - rd_data_x = bypass ? wr_data : reg[rd_addr_x], with the base value selected per bit by mux32_1.
//   - bypass = reset & wr_en & (wr_addr==rd_addr_x) & (rd_addr_x!=ZERO_REG).
//   - rd_addr_x==ZERO_REG always returns 0, regardless of wr_en or wr_data.
//   - Both ports may address the same register; both return the identical value, including the bypass case.
//   Storage
//   - One DATA_W-wide register per index, with a 5->32 one-hot write-enable decoder gated by wr_en.
//   - No partial or byte writes; no read side effects.
//   Timing
//   - Write-back commits in cycle N.
//   - A dependent decode in the same cycle N gets the new value via bypass.
//   - From cycle N+1 the value comes from storage.
// TESTING
//   1. Reset: drive reset=0 mid-run after writing X5=0xDEAD -> rd_data_a(X5)=0 immediately, with no clk edge needed.
//   2. Write/read: write Xi = 0x1111_0000_0000_0000 + i for i=0..30, then read all pairs (i, 30-i) -> each port returns its value.
//   3. Zero reg: wr_en=1, wr_addr=31, wr_data=all-ones; rd_addr_a=rd_addr_b=31 -> both 0 that cycle and after.
//   4. Bypass: X7=0x10; same cycle wr_en=1, X7<-0x99, rd_addr_a=7 -> rd_data_a=0x99 before the edge, and 0x99 from storage after it.
//   5. No-enable: wr_en=0, wr_addr=3, wr_data=0x55 with X3=0x22 -> X3 reads 0x22 before and after the edge.
//   6. Reset collision: reset=0 with wr_en=1, wr_addr=9, wr_data=0xAB across an edge; release reset -> X9 reads 0.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x DATA_W architectural register file, bit-sliced mux32_1 read ports.
// One write port (write-back), two combinational read ports with bypass.
//
// mux32_1 ports:
//   d    in  32  one bit from each of the 32 registers
//   sel  in  5   register index
//   y    out 1   selected bit
//
// regfile_32x64 ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       async active-low reset, clears all registers
//   wr_en      in  1       write-back commit strobe
//   wr_addr    in  5       destination register index
//   wr_data    in  DATA_W  write-back value
//   rd_addr_a  in  5       read port A index
//   rd_addr_b  in  5       read port B index
//   rd_data_a  out DATA_W  read port A value
//   rd_data_b  out DATA_W  read port B value

module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module regfile_32x64 #(
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       wr_sel;

  always_comb begin
    wr_sel = '0;
    if (wr_en && wr_addr != ZR)
      wr_sel[wr_addr] = 1'b1;
  end

  // The zero register is never selected, so it holds its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++)
        if (wr_sel[i])
          regs[i] <= wr_data;
    end
  end

  logic [31:0]       col [DATA_W];
  logic [DATA_W-1:0] base_a;
  logic [DATA_W-1:0] base_b;

  // Transpose storage so each bit position gets its own 32:1 mux.
  for (genvar g = 0; g < DATA_W; g++) begin : g_bit
    for (genvar r = 0; r < 32; r++) begin : g_reg
      assign col[g][r] = regs[r][g];
    end
    mux32_1 u_mux_a (
      .d   (col[g]),
      .sel (rd_addr_a),
      .y   (base_a[g])
    );
    mux32_1 u_mux_b (
      .d   (col[g]),
      .sel (rd_addr_b),
      .y   (base_b[g])
    );
  end

  logic zero_a;
  logic zero_b;
  logic byp_a;
  logic byp_b;

  assign zero_a = (rd_addr_a == ZR);
  assign zero_b = (rd_addr_b == ZR);
  assign byp_a  = reset & wr_en & (wr_addr == rd_addr_a) & ~zero_a;
  assign byp_b  = reset & wr_en & (wr_addr == rd_addr_b) & ~zero_b;

  always_comb begin
    rd_data_a = base_a;
    if (!reset || zero_a)
      rd_data_a = '0;
    else if (byp_a)
      rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = base_b;
    if (!reset || zero_b)
      rd_data_b = '0;
    else if (byp_b)
      rd_data_b = wr_data;
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64.
// Expectations queued at drive time, drained at sample time.

module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string       tag;
    bit          pb;
    logic [63:0] exp;
  } exp_t;

  exp_t sb [$];

  regfile_32x64 dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit pb,
                      input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.pb  = pb;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.pb ? rd_data_b : rd_data_a, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [63:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 5'd1, 64'hFFFF, 5'd1, 5'd2);
    #2;
    push("rst_a", 0, 64'h0);
    push("rst_b", 1, 64'h0);
    drain();
    step();
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd1, 5'd2);
    #2;
    push("rst_wr_dropped", 0, 64'h0);
    drain();

    // 1. async reset mid-cycle
    step();
    drive(1'b1, 5'd5, 64'hDEAD, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
    #2;
    push("x5_pre", 0, 64'hDEAD);
    drain();
    reset = 1'b0;
    #1;
    push("x5_async", 0, 64'h0);
    drain();
    step();
    reset = 1'b1;
    step();
    #2;
    push("x5_cleared", 0, 64'h0);
    drain();

    // 2. fill and read pairs
    for (int i = 0; i <= 30; i++) begin
      step();
      drive(1'b1, 5'(i), 64'h1111_0000_0000_0000 + 64'(i),
            5'd0, 5'd0);
    end
    step();
    wr_en = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      step();
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(30 - i));
      #2;
      push($sformatf("pair_a%0d", i), 0,
           64'h1111_0000_0000_0000 + 64'(i));
      push($sformatf("pair_b%0d", 30 - i), 1,
           64'h1111_0000_0000_0000 + 64'(30 - i));
      drain();
    end

    // 3. zero register
    step();
    drive(1'b1, 5'd31, '1, 5'd31, 5'd31);
    #2;
    push("zr_a_now", 0, 64'h0);
    push("zr_b_now", 1, 64'h0);
    drain();
    step();
    wr_en = 1'b0;
    #2;
    push("zr_a_after", 0, 64'h0);
    push("zr_b_after", 1, 64'h0);
    drain();

    // 4. bypass
    step();
    drive(1'b1, 5'd7, 64'h10, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd7, 64'h99, 5'd7, 5'd7);
    #2;
    push("byp_a", 0, 64'h99);
    push("byp_b", 1, 64'h99);
    drain();
    step();
    wr_en = 1'b0;
    #2;
    push("byp_stored_a", 0, 64'h99);
    push("byp_stored_b", 1, 64'h99);
    drain();

    // 5. no enable
    step();
    drive(1'b1, 5'd3, 64'h22, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd3, 64'h55, 5'd3, 5'd4);
    #2;
    push("noen_pre", 0, 64'h22);
    push("noen_other", 1, 64'h1111_0000_0000_0004);
    drain();
    step();
    #2;
    push("noen_post", 0, 64'h22);
    drain();

    // 6. write during reset
    step();
    reset = 1'b0;
    drive(1'b1, 5'd9, 64'hAB, 5'd9, 5'd9);
    #2;
    push("rstw_a", 0, 64'h0);
    push("rstw_b", 1, 64'h0);
    drain();
    step();
    step();
    reset = 1'b1;
    wr_en = 1'b0;
    #2;
    push("rstw_x9_a", 0, 64'h0);
    push("rstw_x9_b", 1, 64'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
